// File: rtl/tick_gen_multi.sv
// ---------------------------------------------------------------------------
// tick_gen_multi
//
// Multi-channel programmable-period tick generator. Each channel has its own
// divisor and produces a one-cycle tick pulse every (div+1) counting cycles.
// It also produces a phase square wave that toggles on every tick. A channel
// can run periodically, or as a one-shot that stops itself after one tick.
// Out of reset every channel free-runs with RESET_DIV, which matches the old
// single prescaler.
//
// Ports:
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   en           global count enable
//   sync_clr     synchronous clear of all counters, ticks and phases
//   cfg_we       one-cycle configuration write strobe
//   cfg_ch       channel addressed by the write (out-of-range -> ignored)
//   cfg_div      new divisor, period = cfg_div + 1 cycles
//   cfg_en       run enable stored for the channel
//   cfg_oneshot  1 = one-shot, 0 = periodic
//   tick         registered one-cycle pulse per channel
//   phase        registered, toggles on every tick of that channel
//   ch_active    registered run enable per channel
// ---------------------------------------------------------------------------
module tick_gen_multi #(
  parameter int NUM_CH    = 4,
  parameter int DIV_W     = 23,
  parameter int RESET_DIV = 4194303,
  parameter int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              sync_clr,
  input  logic              cfg_we,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic              cfg_en,
  input  logic              cfg_oneshot,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] phase,
  output logic [NUM_CH-1:0] ch_active
);

  logic [DIV_W-1:0]  div_q [NUM_CH];
  logic [DIV_W-1:0]  cnt_q [NUM_CH];
  logic [NUM_CH-1:0] run_q;
  logic [NUM_CH-1:0] oneshot_q;
  logic [NUM_CH-1:0] tick_q;
  logic [NUM_CH-1:0] phase_q;

  logic [NUM_CH-1:0] wr_hit;
  logic [NUM_CH-1:0] counting;
  logic [NUM_CH-1:0] at_term;

  // An out-of-range cfg_ch matches no channel, so the write is dropped
  // without any explicit range check.
  always_comb begin
    wr_hit   = '0;
    counting = '0;
    at_term  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_hit[i]   = cfg_we && (int'(cfg_ch) == i);
      counting[i] = en && run_q[i] && !sync_clr && !wr_hit[i];
      at_term[i]  = (cnt_q[i] == div_q[i]);
    end
  end

  // The counter is zeroed on every write and every clear, and it restarts at
  // the terminal count. So cnt <= div always holds and the counter never
  // wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_q[i] <= DIV_W'(RESET_DIV);
        cnt_q[i] <= '0;
      end
      run_q     <= '1;
      oneshot_q <= '0;
      tick_q    <= '0;
      phase_q   <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (wr_hit[i]) begin
          div_q[i]     <= cfg_div;
          run_q[i]     <= cfg_en;
          oneshot_q[i] <= cfg_oneshot;
          cnt_q[i]     <= '0;
          tick_q[i]    <= 1'b0;
          phase_q[i]   <= 1'b0;
        end else if (sync_clr) begin
          cnt_q[i]     <= '0;
          tick_q[i]    <= 1'b0;
          phase_q[i]   <= 1'b0;
        end else if (counting[i]) begin
          if (at_term[i]) begin
            cnt_q[i]   <= '0;
            tick_q[i]  <= 1'b1;
            phase_q[i] <= ~phase_q[i];
            // A one-shot channel clears its run enable on the same edge that
            // raises its only tick.
            if (oneshot_q[i]) begin
              run_q[i] <= 1'b0;
            end
          end else begin
            cnt_q[i]  <= cnt_q[i] + DIV_W'(1);
            tick_q[i] <= 1'b0;
          end
        end else begin
          tick_q[i] <= 1'b0;
        end
      end
    end
  end

  assign tick      = tick_q;
  assign phase     = phase_q;
  assign ch_active = run_q;

endmodule

// File: tb/tb_tick_gen_multi.sv
// ---------------------------------------------------------------------------
// tb_tick_gen_multi
//
// Bench for tick_gen_multi. It runs two instances from the same stimulus:
//   dut  : NUM_CH=4, RESET_DIV=3
//   dut3 : NUM_CH=3, RESET_DIV=3, where cfg_ch=3 is out of range
//
// A behavioural model keeps, for each channel, the number of counting cycles
// left until its next tick. The model is checked after every clock edge,
// and there are directed latency and pulse-count checks as well.
// ---------------------------------------------------------------------------
module tb_tick_gen_multi;
  localparam int DIV_W = 23;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             en;
  logic             sync_clr;
  logic             cfg_we;
  logic [1:0]       cfg_ch;
  logic [DIV_W-1:0] cfg_div;
  logic             cfg_en;
  logic             cfg_oneshot;
  logic [3:0]       tick, phase, ch_active;
  logic [2:0]       tick3, phase3, act3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tick_gen_multi #(.NUM_CH(4), .DIV_W(DIV_W), .RESET_DIV(3)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .cfg_en(cfg_en), .cfg_oneshot(cfg_oneshot),
    .tick(tick), .phase(phase), .ch_active(ch_active)
  );

  tick_gen_multi #(.NUM_CH(3), .DIV_W(DIV_W), .RESET_DIV(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .en(en), .sync_clr(sync_clr),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_div(cfg_div),
    .cfg_en(cfg_en), .cfg_oneshot(cfg_oneshot),
    .tick(tick3), .phase(phase3), .ch_active(act3)
  );

  // Model slots 0..3 belong to dut and slots 4..6 to dut3. Slot 7 is unused.
  int m_div  [8];
  int m_rem  [8];
  bit m_run  [8];
  bit m_os   [8];
  bit m_tick [8];
  bit m_ph   [8];

  function automatic void model_reset();
    for (int k = 0; k < 8; k++) begin
      m_div[k]  = 3;
      m_rem[k]  = 4;
      m_run[k]  = 1'b1;
      m_os[k]   = 1'b0;
      m_tick[k] = 1'b0;
      m_ph[k]   = 1'b0;
    end
  endfunction

  function automatic void model_edge();
    for (int inst = 0; inst < 2; inst++) begin
      int nch;
      nch = (inst == 0) ? 4 : 3;
      for (int c = 0; c < nch; c++) begin
        int k;
        k = inst * 4 + c;
        if (cfg_we && int'(cfg_ch) == c) begin
          m_div[k]  = int'(cfg_div);
          m_run[k]  = cfg_en;
          m_os[k]   = cfg_oneshot;
          m_rem[k]  = m_div[k] + 1;
          m_tick[k] = 1'b0;
          m_ph[k]   = 1'b0;
        end else if (sync_clr) begin
          m_rem[k]  = m_div[k] + 1;
          m_tick[k] = 1'b0;
          m_ph[k]   = 1'b0;
        end else if (en && m_run[k]) begin
          m_rem[k] = m_rem[k] - 1;
          if (m_rem[k] == 0) begin
            m_tick[k] = 1'b1;
            m_ph[k]   = ~m_ph[k];
            m_rem[k]  = m_div[k] + 1;
            if (m_os[k]) m_run[k] = 1'b0;
          end else begin
            m_tick[k] = 1'b0;
          end
        end else begin
          m_tick[k] = 1'b0;
        end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [3:0] et, ep, ea;
    logic [2:0] et3, ep3, ea3;
    for (int c = 0; c < 4; c++) begin
      et[c] = m_tick[c];
      ep[c] = m_ph[c];
      ea[c] = m_run[c];
    end
    for (int c = 0; c < 3; c++) begin
      et3[c] = m_tick[4 + c];
      ep3[c] = m_ph[4 + c];
      ea3[c] = m_run[4 + c];
    end
    chk("tick",       32'(tick),      32'(et));
    chk("phase",      32'(phase),     32'(ep));
    chk("ch_active",  32'(ch_active), 32'(ea));
    chk("tick3",      32'(tick3),     32'(et3));
    chk("phase3",     32'(phase3),    32'(ep3));
    chk("ch_active3", 32'(act3),      32'(ea3));
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_edge();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    sync_clr    = 1'b0;
    cfg_we      = 1'b0;
    cfg_ch      = 2'd0;
    cfg_div     = '0;
    cfg_en      = 1'b0;
    cfg_oneshot = 1'b0;
  endtask

  task automatic write_cfg(input int ch, input int dv, input bit ce, input bit os);
    cfg_we      = 1'b1;
    cfg_ch      = 2'(ch);
    cfg_div     = DIV_W'(dv);
    cfg_en      = ce;
    cfg_oneshot = os;
  endtask

  initial begin
    int n;
    bit found;

    model_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    idle_inputs();

    // Reset defaults: every channel ticks every 4th edge after release.
    step();
    step();
    rst_n = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      step();
      if (i == 4) chk("reset_first_tick", 32'(tick), 32'hF);
    end

    // Per-channel periods.
    write_cfg(0, 0, 1'b1, 1'b0); step();
    write_cfg(1, 1, 1'b1, 1'b0); step();
    write_cfg(2, 4, 1'b1, 1'b0); step();
    idle_inputs();
    for (int i = 0; i < 20; i++) step();

    // One-shot on ch2: one pulse 6 edges after the write, then nothing.
    write_cfg(2, 5, 1'b1, 1'b1); step();
    idle_inputs();
    n = 0;
    for (int i = 1; i <= 100; i++) begin
      step();
      if (tick[2]) n++;
      if (i == 6) chk("oneshot_edge6", 32'({tick[2], ch_active[2]}), 32'b10);
    end
    chk("oneshot_pulses", 32'(n), 32'd1);

    // Enable freeze: ch1 div=9, en dropped for 7 cycles once cnt reaches 4.
    write_cfg(1, 9, 1'b1, 1'b0); step();
    idle_inputs();
    for (int i = 0; i < 4; i++) step();
    en = 1'b0;
    for (int i = 0; i < 7; i++) step();
    en = 1'b1;
    n = 11;
    found = 1'b0;
    while (!found && n < 40) begin
      step();
      n++;
      if (tick[1]) found = 1'b1;
    end
    chk("freeze_latency", 32'(n), 32'd17);

    // Simultaneous write and sync_clr. On dut3, ch3 is out of range.
    for (int i = 0; i < 5; i++) step();
    write_cfg(3, 2, 1'b1, 1'b0);
    sync_clr = 1'b1;
    step();
    idle_inputs();
    step();
    step();
    step();
    chk("simul_ch3_tick", 32'(tick[3]), 32'd1);

    // Out-of-range write on dut3 without a clear: dut3 must not change.
    for (int i = 0; i < 3; i++) step();
    write_cfg(3, 0, 1'b0, 1'b1); step();
    idle_inputs();
    for (int i = 0; i < 8; i++) step();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cfg_we      = ($urandom % 8) == 0;
      cfg_ch      = 2'($urandom % 4);
      cfg_div     = DIV_W'($urandom % 6);
      cfg_en      = ($urandom % 4) != 0;
      cfg_oneshot = ($urandom % 3) == 0;
      en          = ($urandom % 6) != 0;
      sync_clr    = ($urandom % 25) == 0;
      step();
    end
    idle_inputs();
    en = 1'b1;
    write_cfg(0, 2, 1'b1, 1'b0); step();
    idle_inputs();
    for (int i = 0; i < 4; i++) step();

    // Asynchronous reset between edges.
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("async_active", 32'(ch_active), 32'hF);
    step();
    #1;
    rst_n = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 4) chk("post_reset_tick", 32'(tick), 32'hF);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
